// File: rtl/switch_cell_ingress.sv
// Frame-to-cell ingress: forwards 128-bit frame beats into the core data FIFO and
// follows each forwarded frame with a {portmap, beat count} pointer descriptor.
module switch_cell_ingress #(
    parameter int MAX_BEATS = 95,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [127:0]     in_data,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [3:0]       in_portmap,
    output logic             in_ready,
    output logic [127:0]     i_cell_data_fifo_din,
    output logic             i_cell_data_fifo_wr,
    output logic [15:0]      i_cell_ptr_fifo_din,
    output logic             i_cell_ptr_fifo_wr,
    input  logic             i_cell_bp,
    output logic [CNT_W-1:0] stat_frame_cnt,
    output logic [CNT_W-1:0] stat_drop_cnt,
    output logic [CNT_W-1:0] stat_trunc_cnt,
    output logic [CNT_W-1:0] stat_err_cnt
);

    localparam logic [7:0] MAX_B = 8'(MAX_BEATS);

    typedef enum logic [1:0] {IDLE, XFER, DROP, PTR} state_t;

    state_t           state_q;
    logic             active_q;
    logic [3:0]       portmap_q;
    logic [7:0]       beat_cnt_q;
    logic             trunc_q;
    logic [127:0]     data_din_q;
    logic             data_wr_q;
    logic [15:0]      ptr_din_q;
    logic             ptr_wr_q;
    logic [CNT_W-1:0] frame_cnt_q, drop_cnt_q, trunc_cnt_q, err_cnt_q;
    logic             accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Backpressure only gates frame starts; active_q keeps ready low while in reset.
    assign in_ready = active_q && ((state_q == IDLE) ? !i_cell_bp : (state_q != PTR));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            active_q    <= 1'b0;
            portmap_q   <= '0;
            beat_cnt_q  <= '0;
            trunc_q     <= 1'b0;
            data_din_q  <= '0;
            data_wr_q   <= 1'b0;
            ptr_din_q   <= '0;
            ptr_wr_q    <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            trunc_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            active_q  <= 1'b1;
            data_wr_q <= 1'b0;
            ptr_wr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (!in_sop) begin
                            err_cnt_q <= sat_inc(err_cnt_q);
                        end else if (in_portmap == 4'd0) begin
                            drop_cnt_q <= sat_inc(drop_cnt_q);
                            if (!in_eop) state_q <= DROP;
                        end else begin
                            portmap_q  <= in_portmap;
                            data_din_q <= in_data;
                            data_wr_q  <= 1'b1;
                            beat_cnt_q <= 8'd1;
                            trunc_q    <= 1'b0;
                            state_q    <= in_eop ? PTR : XFER;
                        end
                    end
                end
                XFER: begin
                    if (accept) begin
                        if (beat_cnt_q < MAX_B) begin
                            data_din_q <= in_data;
                            data_wr_q  <= 1'b1;
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                        end else begin
                            trunc_q <= 1'b1;
                        end
                        if (in_sop) err_cnt_q <= sat_inc(err_cnt_q);
                        if (in_eop) state_q <= PTR;
                    end
                end
                DROP: begin
                    if (accept && in_eop) state_q <= IDLE;
                end
                PTR: begin
                    ptr_din_q   <= {4'b0000, portmap_q, beat_cnt_q};
                    ptr_wr_q    <= 1'b1;
                    frame_cnt_q <= sat_inc(frame_cnt_q);
                    if (trunc_q) trunc_cnt_q <= sat_inc(trunc_cnt_q);
                    trunc_q     <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_cell_data_fifo_din = data_din_q;
    assign i_cell_data_fifo_wr  = data_wr_q;
    assign i_cell_ptr_fifo_din  = ptr_din_q;
    assign i_cell_ptr_fifo_wr   = ptr_wr_q;
    assign stat_frame_cnt       = frame_cnt_q;
    assign stat_drop_cnt        = drop_cnt_q;
    assign stat_trunc_cnt       = trunc_cnt_q;
    assign stat_err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_switch_cell_ingress.sv
// Randomized bench for switch_cell_ingress: frames of varied length, portmap and
// protocol errors, checked cycle by cycle against a frame-level reference model.
module tb_switch_cell_ingress;

    logic         clk = 1'b0;
    logic         rstn;
    logic [127:0] in_data;
    logic         in_valid, in_sop, in_eop;
    logic [3:0]   in_portmap;
    logic         in_ready;
    logic [127:0] i_cell_data_fifo_din;
    logic         i_cell_data_fifo_wr;
    logic [15:0]  i_cell_ptr_fifo_din;
    logic         i_cell_ptr_fifo_wr;
    logic         i_cell_bp;
    logic [15:0]  stat_frame_cnt, stat_drop_cnt, stat_trunc_cnt, stat_err_cnt;

    always #5 clk = ~clk;

    switch_cell_ingress #(.MAX_BEATS(95), .CNT_W(16)) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .in_data              (in_data),
        .in_valid             (in_valid),
        .in_sop               (in_sop),
        .in_eop               (in_eop),
        .in_portmap           (in_portmap),
        .in_ready             (in_ready),
        .i_cell_data_fifo_din (i_cell_data_fifo_din),
        .i_cell_data_fifo_wr  (i_cell_data_fifo_wr),
        .i_cell_ptr_fifo_din  (i_cell_ptr_fifo_din),
        .i_cell_ptr_fifo_wr   (i_cell_ptr_fifo_wr),
        .i_cell_bp            (i_cell_bp),
        .stat_frame_cnt       (stat_frame_cnt),
        .stat_drop_cnt        (stat_drop_cnt),
        .stat_trunc_cnt       (stat_trunc_cnt),
        .stat_err_cnt         (stat_err_cnt)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Stimulus: a queue of frame descriptors; a stray entry is a lone non-SOP beat.
    typedef struct {
        int       len;
        logic [3:0] pm;
        bit       stray;
        int       sop_at;
    } frm_t;

    frm_t fq[$];
    frm_t cur;
    bit   s_active = 0;
    int   s_idx    = 0;

    // Reference model: frame-level view of what the core should see.
    bit         m_live, m_fwd, m_drop, m_gap, m_trunc;
    int         m_cnt;
    logic [3:0] m_pm;
    logic       e_dwr, e_pwr;
    logic [127:0] e_ddin;
    logic [15:0]  e_pdin;
    int         e_frame, e_drop, e_trunc, e_err;
    logic       e_ready;

    task automatic model_reset();
        m_live = 0; m_fwd = 0; m_drop = 0; m_gap = 0; m_trunc = 0; m_cnt = 0; m_pm = '0;
        e_dwr = 0; e_pwr = 0; e_ddin = '0; e_pdin = '0;
        e_frame = 0; e_drop = 0; e_trunc = 0; e_err = 0;
    endtask

    function automatic logic model_ready();
        if (!m_live || m_gap) return 1'b0;
        if (m_fwd || m_drop)  return 1'b1;
        return !i_cell_bp;
    endfunction

    // Predicts the outputs visible after the coming clock edge.
    task automatic model_update(input bit acc);
        e_dwr = 0;
        e_pwr = 0;
        if (m_gap) begin
            e_pwr  = 1;
            e_pdin = {4'b0000, m_pm, 8'(m_cnt)};
            e_frame++;
            if (m_trunc) e_trunc++;
            m_trunc = 0;
            m_gap   = 0;
        end else if (m_fwd) begin
            if (acc) begin
                if (m_cnt < 95) begin
                    e_dwr = 1; e_ddin = in_data; m_cnt++;
                end else begin
                    m_trunc = 1;
                end
                if (in_sop) e_err++;
                if (in_eop) begin m_fwd = 0; m_gap = 1; end
            end
        end else if (m_drop) begin
            if (acc && in_eop) m_drop = 0;
        end else if (acc) begin
            if (!in_sop) begin
                e_err++;
            end else if (in_portmap == 4'd0) begin
                e_drop++;
                if (!in_eop) m_drop = 1;
            end else begin
                m_pm = in_portmap; m_cnt = 1; m_trunc = 0;
                e_dwr = 1; e_ddin = in_data;
                if (in_eop) m_gap = 1; else m_fwd = 1;
            end
        end
        m_live = 1;
    endtask

    task automatic check_outputs();
        check("data_wr",   i_cell_data_fifo_wr,  e_dwr);
        check("data_din",  i_cell_data_fifo_din, e_ddin);
        check("ptr_wr",    i_cell_ptr_fifo_wr,   e_pwr);
        check("ptr_din",   i_cell_ptr_fifo_din,  e_pdin);
        check("frame_cnt", stat_frame_cnt, 128'(e_frame));
        check("drop_cnt",  stat_drop_cnt,  128'(e_drop));
        check("trunc_cnt", stat_trunc_cnt, 128'(e_trunc));
        check("err_cnt",   stat_err_cnt,   128'(e_err));
        if (e_pwr) $display("ptr descriptor %04h (frames %0d)", e_pdin, e_frame);
    endtask

    // One clock cycle: check last edge's results, drive new inputs, predict next.
    task automatic step();
        bit acc;
        @(negedge clk);
        check_outputs();
        if (!s_active && fq.size() > 0) begin
            cur = fq.pop_front();
            s_active = 1;
            s_idx = 0;
        end
        i_cell_bp  = ($urandom_range(0, 4) == 0);
        in_data    = {$urandom, $urandom, $urandom, $urandom};
        in_valid   = s_active && ($urandom_range(0, 9) < 8);
        in_portmap = 4'($urandom);
        in_sop     = 1'b0;
        in_eop     = 1'b0;
        if (s_active) begin
            if (cur.stray) begin
                in_eop = 1'($urandom);
            end else begin
                in_sop = (s_idx == 0) || (s_idx == cur.sop_at);
                in_eop = (s_idx == cur.len - 1);
                if (s_idx == 0) in_portmap = cur.pm;
            end
        end
        #1;
        e_ready = model_ready();
        check("in_ready", in_ready, e_ready);
        acc = in_valid && e_ready;
        model_update(acc);
        if (acc) begin
            s_idx++;
            if (cur.stray || s_idx == cur.len) s_active = 0;
        end
    endtask

    function automatic frm_t mk(input int len, input logic [3:0] pm, input bit stray, input int sop_at);
        frm_t f;
        f.len = len; f.pm = pm; f.stray = stray; f.sop_at = sop_at;
        return f;
    endfunction

    task automatic release_reset();
        @(negedge clk);
        rstn = 1'b1;
        in_valid = 1'b0;
        model_update(1'b0);
    endtask

    initial begin
        int cyc;
        rstn = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_data = '0; in_portmap = '0; i_cell_bp = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", in_ready, 1'b0);
        check_outputs();
        release_reset();

        fq.push_back(mk(4,   4'b0101, 0, -1));
        fq.push_back(mk(1,   4'b1000, 0, -1));
        fq.push_back(mk(100, 4'b0010, 0, -1));
        fq.push_back(mk(6,   4'b0000, 0, -1));
        fq.push_back(mk(3,   4'b0011, 0, -1));
        fq.push_back(mk(1,   4'b0000, 1, -1));
        fq.push_back(mk(5,   4'b0110, 0, 2));
        fq.push_back(mk(96,  4'b1111, 0, -1));
        fq.push_back(mk(95,  4'b0001, 0, -1));
        for (int i = 0; i < 60; i++) begin
            int r = $urandom_range(0, 99);
            logic [3:0] pm = (r < 15) ? 4'd0 : 4'($urandom_range(1, 15));
            if (r >= 90)      fq.push_back(mk($urandom_range(90, 110), pm, 0, -1));
            else if (r >= 84) fq.push_back(mk(1, pm, 1, -1));
            else if (r >= 78) fq.push_back(mk($urandom_range(3, 8), pm, 0, $urandom_range(1, 2)));
            else              fq.push_back(mk($urandom_range(1, 8), pm, 0, -1));
        end

        cyc = 0;
        while ((fq.size() > 0 || s_active) && cyc < 20000) begin
            step();
            cyc++;
        end
        if (cyc >= 20000) check("timeout_main", 1'b1, 1'b0);
        repeat (4) step();

        // Reset in the middle of a forwarded frame.
        fq.push_back(mk(10, 4'b0100, 0, -1));
        cyc = 0;
        while (!(s_active && s_idx >= 3) && cyc < 200) begin
            step();
            cyc++;
        end
        if (cyc >= 200) check("timeout_midrst", 1'b1, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        model_reset();
        check("mrst_ready", in_ready, 1'b0);
        check_outputs();
        s_active = 0;
        fq.delete();
        release_reset();

        for (int i = 0; i < 5; i++) fq.push_back(mk($urandom_range(1, 6), 4'($urandom_range(1, 15)), 0, -1));
        cyc = 0;
        while ((fq.size() > 0 || s_active) && cyc < 2000) begin
            step();
            cyc++;
        end
        if (cyc >= 2000) check("timeout_post", 1'b1, 1'b0);
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
